// File: rtl/dct8_in_buffer_pkg.sv
// Shared constants and types for the DCT8 input ping-pong buffer.
// Pure declarations: no latency, no flow control.
package dct8_in_buffer_pkg;

  localparam int DCT8_IN_W   = 12;
  localparam int DCT8_N      = 8;
  localparam int DCT8_HALF   = 4;
  localparam int DCT8_PAIR_W = 2;
  localparam int DCT8_ADDR_W = 3;

  typedef logic [DCT8_PAIR_W-1:0] pair_idx_t;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_sel_t;

  // Address of the butterfly partner x[7-k] for pair index k.
  function automatic logic [DCT8_ADDR_W-1:0] pair_mate(input pair_idx_t k);
    return DCT8_ADDR_W'(DCT8_N - 1) - DCT8_ADDR_W'(k);
  endfunction

endpackage

// File: rtl/dct8_in_buffer_if.sv
// Sample-in / butterfly-pair-out handshake bundle of the DCT8 input buffer.
// Both directions are valid/ready; slave is the buffer, master is its environment.
interface dct8_in_buffer_if
  import dct8_in_buffer_pkg::*;
#(
  parameter int DATA_W = DCT8_IN_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_a;
  logic signed [DATA_W-1:0] out_b;
  pair_idx_t                out_idx;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_idx, out_last
  );

endinterface

// File: rtl/dct8_mem_bank.sv
// Small dual-port RAM bank with registered read data on both ports.
// One-cycle read latency; no flow control, caller owns port arbitration.
module dct8_mem_bank
  import dct8_in_buffer_pkg::*;
#(
  parameter int DATA_W = DCT8_IN_W,
  parameter int DEPTH  = DCT8_N,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-old-data semantics; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/dct8_in_buffer.sv
// Ping-pong buffer: fills 8-sample blocks, drains them as (x[k], x[7-k]) pairs.
// Pair 0 valid one edge after the 8th sample; output holds under stall, input stalls only with both banks full.
module dct8_in_buffer
  import dct8_in_buffer_pkg::*;
#(
  parameter int DATA_W = DCT8_IN_W,
  parameter int ADDR_W = DCT8_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  dct8_in_buffer_if.slave  bus
);

  bank_sel_t         wsel;
  bank_sel_t         rsel;
  logic [ADDR_W-1:0] wcnt;
  pair_idx_t         rcnt;
  pair_idx_t         rd_addr;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              done_issue;
  logic              out_valid;
  pair_idx_t         out_idx;
  logic              out_last;

  logic              wr_fire;
  logic              blk_done;
  logic              rd_fire;
  logic              rel_fire;
  logic              issue;
  pair_idx_t         rd_k;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;

  logic              bank_we_a   [2];
  logic [ADDR_W-1:0] bank_addr_a [2];
  logic [DATA_W-1:0] bank_dout_a [2];
  logic [DATA_W-1:0] bank_dout_b [2];

  assign bus.in_ready = !full[wsel];
  assign wr_fire      = bus.in_valid && !full[wsel];
  assign blk_done     = wr_fire && (wcnt == ADDR_W'(DCT8_N - 1));

  assign rd_fire  = out_valid && bus.out_ready;
  assign rel_fire = rd_fire && out_last;
  assign issue    = full[rsel] && !done_issue && (!out_valid || bus.out_ready);

  // When stalled the read addresses replay rd_addr so the registered bank outputs stay put.
  assign rd_k      = issue ? rcnt : rd_addr;
  assign rd_addr_a = ADDR_W'(rd_k);
  assign rd_addr_b = ADDR_W'(pair_mate(rd_k));

  always_comb begin
    full_nxt = full;
    if (rel_fire) full_nxt[rsel] = 1'b0;
    if (blk_done) full_nxt[wsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wsel       <= BANK0;
      rsel       <= BANK0;
      wcnt       <= '0;
      rcnt       <= '0;
      rd_addr    <= '0;
      full       <= 2'b00;
      done_issue <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
    end else begin
      full <= full_nxt;

      if (wr_fire) begin
        wcnt <= blk_done ? '0 : wcnt + ADDR_W'(1);
      end
      if (blk_done) begin
        wsel <= (wsel == BANK0) ? BANK1 : BANK0;
      end

      if (issue) begin
        rcnt      <= rcnt + pair_idx_t'(1);
        rd_addr   <= rcnt;
        out_idx   <= rcnt;
        out_last  <= (rcnt == pair_idx_t'(DCT8_HALF - 1));
        out_valid <= 1'b1;
      end else if (rd_fire) begin
        out_valid <= 1'b0;
      end

      if (rel_fire) begin
        done_issue <= 1'b0;
        rsel       <= (rsel == BANK0) ? BANK1 : BANK0;
      end else if (issue && (rcnt == pair_idx_t'(DCT8_HALF - 1))) begin
        done_issue <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    logic fill_mode;

    // A bank is steered to the write side only while it is the fill target and not holding a block.
    assign fill_mode      = (1'(wsel) == 1'(i)) && !full[i];
    assign bank_we_a[i]   = fill_mode && wr_fire;
    assign bank_addr_a[i] = fill_mode ? wcnt : rd_addr_a;

    dct8_mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DCT8_N),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk    (clk),
      .we_a   (bank_we_a[i]),
      .addr_a (bank_addr_a[i]),
      .din_a  (bus.in_data),
      .dout_a (bank_dout_a[i]),
      .we_b   (1'b0),
      .addr_b (rd_addr_b),
      .din_b  ('0),
      .dout_b (bank_dout_b[i])
    );
  end

  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_idx;
  assign bus.out_last  = out_last;
  assign bus.out_a     = (rsel == BANK1) ? bank_dout_a[1] : bank_dout_a[0];
  assign bus.out_b     = (rsel == BANK1) ? bank_dout_b[1] : bank_dout_b[0];

  stall_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !bus.out_ready) |=>
      (out_valid && $stable(bus.out_a) && $stable(bus.out_b) && $stable(out_idx) && $stable(out_last)));

endmodule

// File: tb/tb_dct8_in_buffer.sv
// Bench for dct8_in_buffer: table-driven blocks, corner sequences and randomized streaming
// checked against a block/pair queue model.
module tb_dct8_in_buffer;
  import dct8_in_buffer_pkg::*;

  localparam int W = DCT8_IN_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct8_in_buffer_if #(.DATA_W(W)) bus ();

  dct8_in_buffer #(.DATA_W(W), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    int                  idx;
    bit                  last;
  } pair_t;

  typedef struct {
    int x  [8];
    int ea [4];
    int eb [4];
    int stall;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic signed [W-1:0] blk_q[$];
  pair_t               exp_q[$];
  int                  held;
  int                  n_in;
  int                  n_out;
  vec_t                vecs [3];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    blk_q.delete();
    exp_q.delete();
    held = 0;
  endtask

  // Every 8 accepted samples form one block that yields pairs (x[k], x[7-k]).
  task automatic model_write(input logic signed [W-1:0] d);
    pair_t p;
    blk_q.push_back(d);
    if (blk_q.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        p.a    = blk_q[k];
        p.b    = blk_q[7-k];
        p.idx  = k;
        p.last = (k == 3);
        exp_q.push_back(p);
      end
      blk_q.delete();
      held++;
    end
  endtask

  // Observe the transfers due at the next edge, advance one cycle, then check hold and in_ready.
  task automatic tick();
    bit wf, rf, st;
    pair_t p;
    logic signed [W-1:0] ha, hb;
    logic [1:0] hidx;
    logic hlast;
    wf = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    rf = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    st = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
    ha = bus.out_a; hb = bus.out_b; hidx = bus.out_idx; hlast = bus.out_last;
    if (rf) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pair_unexpected: got a=%0d b=%0d, expected no pair", bus.out_a, bus.out_b);
      end else begin
        p = exp_q.pop_front();
        chk("pair_a", bus.out_a, p.a);
        chk("pair_b", bus.out_b, p.b);
        chk("pair_idx", bus.out_idx, p.idx);
        chk("pair_last", bus.out_last, p.last);
        if (p.last) held--;
        n_out++;
      end
    end
    if (wf) begin
      n_in++;
      model_write(bus.in_data);
    end
    @(posedge clk);
    #1;
    if (st) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_a", bus.out_a, ha);
      chk("hold_b", bus.out_b, hb);
      chk("hold_idx", bus.out_idx, hidx);
      chk("hold_last", bus.out_last, hlast);
    end
    chk("in_ready", bus.in_ready, held < 2);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && g < 300) begin
      tick();
      g++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, o0, g;

    vecs[0].x  = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecs[0].ea = '{1, 2, 3, 4};
    vecs[0].eb = '{8, 7, 6, 5};
    vecs[0].stall = 0;
    vecs[1].x  = '{-8, -7, -6, -5, -4, -3, -2, -1};
    vecs[1].ea = '{-8, -7, -6, -5};
    vecs[1].eb = '{-1, -2, -3, -4};
    vecs[1].stall = 5;
    vecs[2].x  = '{2047, -2048, 0, -1, 1, 100, -100, 5};
    vecs[2].ea = '{2047, -2048, 0, -1};
    vecs[2].eb = '{5, -100, 100, 1};
    vecs[2].stall = 2;

    n_in = 0;
    n_out = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);

    // Table-driven single blocks with exact pair timing.
    for (int v = 0; v < 3; v++) begin
      bus.out_ready = (vecs[v].stall == 0);
      for (int i = 0; i < 8; i++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'(vecs[v].x[i]);
        tick();
      end
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_no_early_pair", v), bus.out_valid, 0);
      tick();
      for (int s = 0; s < vecs[v].stall; s++) begin
        chk($sformatf("v%0d_stall%0d_valid", v, s), bus.out_valid, 1);
        chk($sformatf("v%0d_stall%0d_a", v, s), bus.out_a, vecs[v].ea[0]);
        chk($sformatf("v%0d_stall%0d_b", v, s), bus.out_b, vecs[v].eb[0]);
        tick();
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_k%0d_valid", v, k), bus.out_valid, 1);
        chk($sformatf("v%0d_k%0d_a", v, k), bus.out_a, vecs[v].ea[k]);
        chk($sformatf("v%0d_k%0d_b", v, k), bus.out_b, vecs[v].eb[k]);
        chk($sformatf("v%0d_k%0d_idx", v, k), bus.out_idx, k);
        chk($sformatf("v%0d_k%0d_last", v, k), bus.out_last, k == 3);
        tick();
      end
      chk($sformatf("v%0d_idle_valid", v), bus.out_valid, 0);
      chk($sformatf("v%0d_queue_empty", v), exp_q.size(), 0);
    end

    // Both banks full: input blocks until block 0's last pair is taken.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(i * 3 - 20);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pp_full_in_ready", bus.in_ready, 0);
    chk("pp_pending_pairs", exp_q.size(), 8);
    bus.out_ready = 1'b1;
    drain();

    // Sustained one sample per clock with the output always ready.
    s0 = n_in;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("sustain_accepted", n_in - s0, 64);
    drain();

    // Randomized output backpressure.
    s0 = n_in;
    o0 = n_out;
    g  = 0;
    bus.in_valid = 1'b1;
    while ((n_in - s0) < 64 && g < 2000) begin
      bus.in_data   = W'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("stream_samples", n_in - s0, 64);
    chk("stream_pairs", n_out - o0, 32);

    // Block B completes on the same edge block A's last pair is accepted.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'((i < 8) ? (100 + i) : (200 + i - 8));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("se_last_valid", bus.out_valid, 1);
    chk("se_last_flag", bus.out_last, 1);
    chk("se_last_a", bus.out_a, 103);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(207);
    tick();
    bus.in_valid = 1'b0;
    chk("se_gap_valid", bus.out_valid, 0);
    chk("se_in_ready", bus.in_ready, 1);
    tick();
    chk("se_b0_valid", bus.out_valid, 1);
    chk("se_b0_a", bus.out_a, 200);
    chk("se_b0_b", bus.out_b, 207);
    drain();

    // Reset with one full block pending and a partial block in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'((i < 8) ? (i + 1) : (20 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mr_pending_valid", bus.out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(9 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("mr_p0_valid", bus.out_valid, 1);
    chk("mr_p0_a", bus.out_a, 9);
    chk("mr_p0_b", bus.out_b, 16);
    chk("mr_p0_idx", bus.out_idx, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
